// File: rtl/mem_protect_unit.sv
// Memory protection unit: checks user-mode PC and data accesses against a reserved
// area and a programmable region table, and latches a registered fault report.
module mem_protect_unit #(
  parameter int                 ADDR_W       = 16,
  parameter int                 NUM_REGIONS  = 4,
  parameter logic [ADDR_W-1:0]  RESERVE_AREA = 16'h0100,
  localparam int                CFG_W        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        Mode,
  input  logic [ADDR_W-1:0] Current_PC,
  input  logic              J,
  input  logic              memre,
  input  logic              memwe,
  input  logic [ADDR_W-1:0] p0,
  input  logic              cfg_we,
  input  logic [CFG_W-1:0]  cfg_region,
  input  logic [1:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_wdata,
  input  logic              fault_ack,
  output logic              Illegal_PC,
  output logic              Illegal_Memory,
  output logic              fault_req,
  output logic [1:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [7:0]        fault_count
);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [ADDR_W-1:0] base_q  [NUM_REGIONS];
  logic [ADDR_W-1:0] limit_q [NUM_REGIONS];
  logic [2:0]        perm_q  [NUM_REGIONS];

  state_t            state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        count_q, count_d;

  logic user, hit, r_ok, w_ok, violation;
  logic [1:0]        new_cause;
  logic [ADDR_W-1:0] new_addr;

  assign user = ~Mode[1] & Mode[0];

  // Lowest-index enabled region containing p0 decides the permissions.
  always_comb begin
    hit  = 1'b0;
    r_ok = 1'b0;
    w_ok = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit && perm_q[i][2] && (base_q[i] <= p0) && (p0 <= limit_q[i])) begin
        hit  = 1'b1;
        r_ok = perm_q[i][1];
        w_ok = perm_q[i][0];
      end
    end
  end

  assign Illegal_PC     = user & ~J & (Current_PC < RESERVE_AREA);
  assign Illegal_Memory = user & (memre | memwe) &
                          ((p0 < RESERVE_AREA) | (hit & memre & ~r_ok) | (hit & memwe & ~w_ok));
  assign violation      = Illegal_PC | Illegal_Memory;

  assign new_cause = Illegal_PC ? 2'b01 : (memwe ? 2'b11 : 2'b10);
  assign new_addr  = Illegal_PC ? Current_PC : p0;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (violation) begin
          state_d = PENDING;
          cause_d = new_cause;
          addr_d  = new_addr;
        end
      end
      PENDING: begin
        if (fault_ack) begin
          if (violation) begin
            cause_d = new_cause;
            addr_d  = new_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_d = (violation && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= '0;
      addr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
        perm_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      if (cfg_we && !user) begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (cfg_region == i[CFG_W-1:0]) begin
            case (cfg_field)
              2'd0:    base_q[i]  <= cfg_wdata;
              2'd1:    limit_q[i] <= cfg_wdata;
              2'd2:    perm_q[i]  <= cfg_wdata[2:0];
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign fault_req   = (state_q == PENDING);
  assign fault_cause = cause_q;
  assign fault_addr  = addr_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_mem_protect_unit.sv
// Directed bench for mem_protect_unit: reserved-area checks, region table,
// fault FSM, counter saturation and reset behaviour.
module tb_mem_protect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  Mode;
  logic [15:0] Current_PC;
  logic        J, memre, memwe;
  logic [15:0] p0;
  logic        cfg_we;
  logic [1:0]  cfg_region;
  logic [1:0]  cfg_field;
  logic [15:0] cfg_wdata;
  logic        fault_ack;
  logic        Illegal_PC, Illegal_Memory, fault_req;
  logic [1:0]  fault_cause;
  logic [15:0] fault_addr;
  logic [7:0]  fault_count;

  int n_vec = 0;
  int n_err = 0;

  mem_protect_unit dut (
    .clk(clk), .rst_n(rst_n), .Mode(Mode), .Current_PC(Current_PC), .J(J),
    .memre(memre), .memwe(memwe), .p0(p0), .cfg_we(cfg_we), .cfg_region(cfg_region),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .fault_ack(fault_ack),
    .Illegal_PC(Illegal_PC), .Illegal_Memory(Illegal_Memory), .fault_req(fault_req),
    .fault_cause(fault_cause), .fault_addr(fault_addr), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiet kernel-mode inputs: no violation possible.
  task automatic idle_inputs();
    Mode = 2'b00; Current_PC = 16'h1000; J = 1'b0; memre = 1'b0; memwe = 1'b0;
    p0 = 16'h1000; cfg_we = 1'b0; cfg_region = 2'd0; cfg_field = 2'd0;
    cfg_wdata = 16'h0000; fault_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] r, input logic [1:0] f, input logic [15:0] d);
    Mode = 2'b00; cfg_we = 1'b1; cfg_region = r; cfg_field = f; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // User-mode data access with a legal PC.
  task automatic user_access(input logic re, input logic we, input logic [15:0] a);
    Mode = 2'b01; Current_PC = 16'h1000; J = 1'b0; memre = re; memwe = we; p0 = a;
    #1;
  endtask

  task automatic ack_clear();
    idle_inputs();
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_vec++; if (fault_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", fault_req); end
    n_vec++; if (fault_cause !== 2'b00) begin n_err++; $display("FAIL rst_cause got %b want 00", fault_cause); end
    n_vec++; if (fault_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr got %h want 0000", fault_addr); end
    n_vec++; if (fault_count !== 8'h00) begin n_err++; $display("FAIL rst_count got %h want 00", fault_count); end
    n_vec++; if ({Illegal_PC, Illegal_Memory} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {Illegal_PC, Illegal_Memory}); end
  endtask

  task automatic test_illegal_pc();
    do_reset();
    Mode = 2'b01; J = 1'b0; Current_PC = 16'h00F0;
    #1;
    n_vec++; if (Illegal_PC !== 1'b1) begin n_err++; $display("FAIL pc_flag got %b want 1", Illegal_PC); end
    n_vec++; if (Illegal_Memory !== 1'b0) begin n_err++; $display("FAIL pc_memflag got %b want 0", Illegal_Memory); end
    n_vec++; if (fault_req !== 1'b0) begin n_err++; $display("FAIL pc_req_early got %b want 0", fault_req); end
    tick();
    idle_inputs();
    n_vec++; if (fault_req !== 1'b1) begin n_err++; $display("FAIL pc_req got %b want 1", fault_req); end
    n_vec++; if (fault_cause !== 2'b01) begin n_err++; $display("FAIL pc_cause got %b want 01", fault_cause); end
    n_vec++; if (fault_addr !== 16'h00F0) begin n_err++; $display("FAIL pc_addr got %h want 00F0", fault_addr); end
    n_vec++; if (fault_count !== 8'd1) begin n_err++; $display("FAIL pc_count got %0d want 1", fault_count); end
    Mode = 2'b01; J = 1'b1; Current_PC = 16'h00F0; #1;
    n_vec++; if (Illegal_PC !== 1'b0) begin n_err++; $display("FAIL pc_jump got %b want 0", Illegal_PC); end
    Mode = 2'b00; J = 1'b0; #1;
    n_vec++; if (Illegal_PC !== 1'b0) begin n_err++; $display("FAIL pc_kernel got %b want 0", Illegal_PC); end
    Mode = 2'b11; #1;
    n_vec++; if (Illegal_PC !== 1'b0) begin n_err++; $display("FAIL pc_mode11 got %b want 0", Illegal_PC); end
    Mode = 2'b01; Current_PC = 16'h0100; #1;
    n_vec++; if (Illegal_PC !== 1'b0) begin n_err++; $display("FAIL pc_edge100 got %b want 0", Illegal_PC); end
    Current_PC = 16'h00FF; #1;
    n_vec++; if (Illegal_PC !== 1'b1) begin n_err++; $display("FAIL pc_edge0ff got %b want 1", Illegal_PC); end
    ack_clear();
    n_vec++; if (fault_req !== 1'b0) begin n_err++; $display("FAIL pc_ack got %b want 0", fault_req); end
    n_vec++; if (fault_count !== 8'd1) begin n_err++; $display("FAIL pc_count_hold got %0d want 1", fault_count); end
    fault_ack = 1'b1; tick(); fault_ack = 1'b0;
    n_vec++; if (fault_req !== 1'b0) begin n_err++; $display("FAIL idle_ack got %b want 0", fault_req); end
  endtask

  task automatic test_region_perm();
    do_reset();
    cfg_write(2'd0, 2'd0, 16'h2000);
    cfg_write(2'd0, 2'd1, 16'h2FFF);
    cfg_write(2'd0, 2'd2, 16'h0006);
    user_access(1'b0, 1'b1, 16'h2FFF);
    n_vec++; if (Illegal_Memory !== 1'b1) begin n_err++; $display("FAIL reg_wr_limit got %b want 1", Illegal_Memory); end
    tick();
    idle_inputs();
    n_vec++; if (fault_cause !== 2'b11) begin n_err++; $display("FAIL reg_cause got %b want 11", fault_cause); end
    n_vec++; if (fault_addr !== 16'h2FFF) begin n_err++; $display("FAIL reg_addr got %h want 2FFF", fault_addr); end
    user_access(1'b1, 1'b0, 16'h2FFF);
    n_vec++; if (Illegal_Memory !== 1'b0) begin n_err++; $display("FAIL reg_rd got %b want 0", Illegal_Memory); end
    user_access(1'b0, 1'b1, 16'h3000);
    n_vec++; if (Illegal_Memory !== 1'b0) begin n_err++; $display("FAIL reg_wr_above got %b want 0", Illegal_Memory); end
    user_access(1'b0, 1'b1, 16'h2000);
    n_vec++; if (Illegal_Memory !== 1'b1) begin n_err++; $display("FAIL reg_wr_base got %b want 1", Illegal_Memory); end
    user_access(1'b0, 1'b1, 16'h1FFF);
    n_vec++; if (Illegal_Memory !== 1'b0) begin n_err++; $display("FAIL reg_wr_below got %b want 0", Illegal_Memory); end
    user_access(1'b1, 1'b1, 16'h2800);
    n_vec++; if (Illegal_Memory !== 1'b1) begin n_err++; $display("FAIL reg_rw got %b want 1", Illegal_Memory); end
    ack_clear();
    cfg_write(2'd2, 2'd0, 16'h4000);
    cfg_write(2'd2, 2'd1, 16'h3000);
    cfg_write(2'd2, 2'd2, 16'h0004);
    user_access(1'b1, 1'b1, 16'h3800);
    n_vec++; if (Illegal_Memory !== 1'b0) begin n_err++; $display("FAIL reg_inverted got %b want 0", Illegal_Memory); end
    user_access(1'b1, 1'b0, 16'h0080);
    tick();
    idle_inputs();
    n_vec++; if (fault_cause !== 2'b10) begin n_err++; $display("FAIL rd_cause got %b want 10", fault_cause); end
    n_vec++; if (fault_addr !== 16'h0080) begin n_err++; $display("FAIL rd_addr got %h want 0080", fault_addr); end
    ack_clear();
    user_access(1'b1, 1'b1, 16'h0090);
    tick();
    idle_inputs();
    n_vec++; if (fault_cause !== 2'b11) begin n_err++; $display("FAIL rw_cause got %b want 11", fault_cause); end
    ack_clear();
  endtask

  task automatic test_overlap();
    do_reset();
    cfg_write(2'd0, 2'd0, 16'h2000);
    cfg_write(2'd0, 2'd1, 16'h2FFF);
    cfg_write(2'd0, 2'd2, 16'h0007);
    cfg_write(2'd1, 2'd0, 16'h2000);
    cfg_write(2'd1, 2'd1, 16'h2FFF);
    cfg_write(2'd1, 2'd2, 16'h0004);
    user_access(1'b0, 1'b1, 16'h2800);
    n_vec++; if (Illegal_Memory !== 1'b0) begin n_err++; $display("FAIL ovl_r0 got %b want 0", Illegal_Memory); end
    cfg_write(2'd0, 2'd2, 16'h0000);
    user_access(1'b0, 1'b1, 16'h2800);
    n_vec++; if (Illegal_Memory !== 1'b1) begin n_err++; $display("FAIL ovl_r1 got %b want 1", Illegal_Memory); end
    idle_inputs();
  endtask

  task automatic test_pending();
    do_reset();
    Mode = 2'b01; J = 1'b0; Current_PC = 16'h00F0;
    tick();
    for (int k = 0; k < 3; k++) begin
      user_access(1'b0, 1'b1, 16'h0010 + 16'(k));
      tick();
    end
    idle_inputs();
    n_vec++; if (fault_cause !== 2'b01) begin n_err++; $display("FAIL pend_cause got %b want 01", fault_cause); end
    n_vec++; if (fault_addr !== 16'h00F0) begin n_err++; $display("FAIL pend_addr got %h want 00F0", fault_addr); end
    n_vec++; if (fault_req !== 1'b1) begin n_err++; $display("FAIL pend_req got %b want 1", fault_req); end
    n_vec++; if (fault_count !== 8'd4) begin n_err++; $display("FAIL pend_count got %0d want 4", fault_count); end
    ack_clear();
    n_vec++; if (fault_req !== 1'b0) begin n_err++; $display("FAIL pend_ack got %b want 0", fault_req); end
    Mode = 2'b01; J = 1'b0; Current_PC = 16'h00F0;
    tick();
    user_access(1'b1, 1'b0, 16'h0020);
    fault_ack = 1'b1;
    tick();
    idle_inputs();
    n_vec++; if (fault_req !== 1'b1) begin n_err++; $display("FAIL ackviol_req got %b want 1", fault_req); end
    n_vec++; if (fault_cause !== 2'b10) begin n_err++; $display("FAIL ackviol_cause got %b want 10", fault_cause); end
    n_vec++; if (fault_addr !== 16'h0020) begin n_err++; $display("FAIL ackviol_addr got %h want 0020", fault_addr); end
    ack_clear();
    Mode = 2'b01; J = 1'b0; Current_PC = 16'h0050; memre = 1'b1; p0 = 16'h0080;
    #1;
    n_vec++; if ({Illegal_PC, Illegal_Memory} !== 2'b11) begin n_err++; $display("FAIL both_flags got %b want 11", {Illegal_PC, Illegal_Memory}); end
    tick();
    idle_inputs();
    n_vec++; if (fault_cause !== 2'b01) begin n_err++; $display("FAIL both_cause got %b want 01", fault_cause); end
    n_vec++; if (fault_addr !== 16'h0050) begin n_err++; $display("FAIL both_addr got %h want 0050", fault_addr); end
    n_vec++; if (fault_count !== 8'd7) begin n_err++; $display("FAIL both_count got %0d want 7", fault_count); end
  endtask

  task automatic test_cfg_user_and_sat();
    do_reset();
    cfg_write(2'd0, 2'd0, 16'h2000);
    cfg_write(2'd0, 2'd1, 16'h2FFF);
    cfg_write(2'd0, 2'd2, 16'h0006);
    Mode = 2'b01; J = 1'b1; cfg_we = 1'b1; cfg_region = 2'd0; cfg_field = 2'd2; cfg_wdata = 16'h0007;
    tick();
    cfg_we = 1'b0;
    cfg_write(2'd0, 2'd3, 16'h0000);
    user_access(1'b0, 1'b1, 16'h2800);
    n_vec++; if (Illegal_Memory !== 1'b1) begin n_err++; $display("FAIL cfg_user got %b want 1", Illegal_Memory); end
    n_vec++; if (fault_count !== 8'd0) begin n_err++; $display("FAIL cfg_count got %0d want 0", fault_count); end
    for (int k = 0; k < 300; k++) tick();
    idle_inputs();
    n_vec++; if (fault_count !== 8'hFF) begin n_err++; $display("FAIL sat_count got %h want FF", fault_count); end
    n_vec++; if (fault_req !== 1'b1) begin n_err++; $display("FAIL sat_req got %b want 1", fault_req); end
  endtask

  task automatic test_reset_pending();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (fault_req !== 1'b0) begin n_err++; $display("FAIL rstp_req got %b want 0", fault_req); end
    n_vec++; if (fault_count !== 8'h00) begin n_err++; $display("FAIL rstp_count got %h want 00", fault_count); end
    n_vec++; if (fault_cause !== 2'b00) begin n_err++; $display("FAIL rstp_cause got %b want 00", fault_cause); end
    user_access(1'b0, 1'b1, 16'h2800);
    n_vec++; if (Illegal_Memory !== 1'b0) begin n_err++; $display("FAIL rstp_region got %b want 0", Illegal_Memory); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_illegal_pc();
    test_region_perm();
    test_overlap();
    test_pending();
    test_cfg_user_and_sat();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
